// File: rtl/arb_fifo_scoreboard_if.sv
// Bus bundle observed by the arbitrated-FIFO scoreboard: per-channel push/pop/data
// and the shared FIFO output, plus the combinational output-valid indication.
interface arb_fifo_scoreboard_if #(
  parameter int NUM_REQS = 4,
  parameter int WIDTH    = 8
);
  logic                      start;
  logic [NUM_REQS-1:0]       push;
  logic [NUM_REQS-1:0]       pop;
  logic [NUM_REQS*WIDTH-1:0] flat_data_in;
  logic [WIDTH-1:0]          data_out;
  logic                      data_out_vld;

  modport master (
    output start, push, pop, flat_data_in, data_out,
    input  data_out_vld
  );

  modport slave (
    input  start, push, pop, flat_data_in, data_out,
    output data_out_vld
  );
endinterface

// File: rtl/arb_fifo_scoreboard.sv
// Multi-channel tag-and-track scoreboard for the arbitrated FIFO array.
// Optional per-channel latency timeout: define SCOREBOARD_LATENCY_CHECK_EN.
module arb_fifo_scoreboard #(
  parameter int NUM_REQS = 4,
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int CNTW     = $clog2(DEPTH + 1),
  parameter int MAX_LAT  = 64
) (
  input  logic                clk,
  input  logic                rst,
  arb_fifo_scoreboard_if.slave bus,
  output logic [NUM_REQS-1:0] armed,
  output logic [NUM_REQS-1:0] done,
  output logic [NUM_REQS-1:0] fail,
  output logic                proto_err,
  output logic                prop_signal
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_DONE, S_FAIL} state_t;

  if (NUM_REQS < 1 || DEPTH < 2 || MAX_LAT < 1) begin : g_bad_param
    $error("arb_fifo_scoreboard: illegal parameterisation");
  end

  logic                multi_pop;
  logic [NUM_REQS-1:0] chan_err;

  assign bus.data_out_vld = |bus.pop;
  // Clearing the lowest set bit leaves something only if two or more pops are high.
  assign multi_pop   = |(bus.pop & (bus.pop - NUM_REQS'(1)));
  assign prop_signal = ~|fail & ~proto_err;

  for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_ch
    state_t           state;
    logic [CNTW-1:0]  cnt;
    logic [CNTW-1:0]  pend;
    logic [WIDTH-1:0] tag;
    logic [WIDTH-1:0] din;
    logic             under;
    logic             over;
    logic             arm_ok;
    logic             armed_q;
    logic             done_q;
    logic             fail_q;
`ifdef SCOREBOARD_LATENCY_CHECK_EN
    localparam int LATW = $clog2(MAX_LAT + 1);
    logic [LATW-1:0] lat;
`endif

    assign din          = bus.flat_data_in[gi*WIDTH +: WIDTH];
    assign under        = bus.pop[gi] && (cnt == '0);
    assign over         = bus.push[gi] && !bus.pop[gi] && (cnt == CNTW'(DEPTH));
    assign chan_err[gi] = under | over;
    assign arm_ok       = bus.start && bus.push[gi] && !chan_err[gi];

    assign armed[gi] = armed_q;
    assign done[gi]  = done_q;
    assign fail[gi]  = fail_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        state   <= S_IDLE;
        cnt     <= '0;
        pend    <= '0;
        tag     <= '0;
        armed_q <= 1'b0;
        done_q  <= 1'b0;
        fail_q  <= 1'b0;
`ifdef SCOREBOARD_LATENCY_CHECK_EN
        lat     <= '0;
`endif
      end else begin
        if (!chan_err[gi])
          cnt <= cnt + CNTW'(bus.push[gi]) - CNTW'(bus.pop[gi]);

        case (state)
          S_IDLE, S_DONE: begin
            if (arm_ok) begin
              state   <= S_ARMED;
              tag     <= din;
              // Words still queued ahead of the tagged one after this cycle's pop.
              pend    <= cnt - CNTW'(bus.pop[gi]);
              armed_q <= 1'b1;
              done_q  <= 1'b0;
`ifdef SCOREBOARD_LATENCY_CHECK_EN
              lat     <= '0;
`endif
            end
          end
          S_ARMED: begin
            if (bus.pop[gi] && pend == '0) begin
              armed_q <= 1'b0;
              if (bus.data_out == tag) begin
                state  <= S_DONE;
                done_q <= 1'b1;
              end else begin
                state  <= S_FAIL;
                fail_q <= 1'b1;
              end
            end else begin
              if (bus.pop[gi])
                pend <= pend - CNTW'(1);
`ifdef SCOREBOARD_LATENCY_CHECK_EN
              // A match in the expiring cycle is taken by the branch above.
              if (lat == LATW'(MAX_LAT - 1)) begin
                state   <= S_FAIL;
                armed_q <= 1'b0;
                fail_q  <= 1'b1;
              end else begin
                lat <= lat + LATW'(1);
              end
`endif
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      proto_err <= 1'b0;
    else if (multi_pop || (|chan_err))
      proto_err <= 1'b1;
  end

endmodule

// File: tb/tb_arb_fifo_scoreboard.sv
// Directed bench for arb_fifo_scoreboard: queue-based reference model compared
// every cycle, plus literal checks at the key points of each scenario.
module tb_arb_fifo_scoreboard;
  localparam int NR  = 4;
  localparam int W   = 8;
  localparam int D   = 8;
  localparam int LAT = 4;

  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_DONE  = 2;
  localparam int M_FAIL  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] armed, done, fail;
  logic          proto_err, prop_signal;

  arb_fifo_scoreboard_if #(.NUM_REQS(NR), .WIDTH(W)) bus ();

  arb_fifo_scoreboard #(
    .NUM_REQS(NR), .WIDTH(W), .DEPTH(D), .MAX_LAT(LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .armed      (armed),
    .done       (done),
    .fail       (fail),
    .proto_err  (proto_err),
    .prop_signal(prop_signal)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Each FIFO entry holds the word in bits [7:0]; bit 8 marks the tagged word.
  int q [NR][$];
  int m_st [NR];
  int m_arm_cyc [NR];
  bit m_proto;
  int edge_n = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance the reference model by one clock edge using the inputs held this cycle.
  task automatic model_step();
    if (rst) begin
      for (int i = 0; i < NR; i++) begin
        q[i].delete();
        m_st[i] = M_IDLE;
      end
      m_proto = 1'b0;
    end else begin
      if ($countones(bus.pop) > 1) m_proto = 1'b1;
      for (int i = 0; i < NR; i++) begin
        int  prev;
        bit  pu, po, legal;
        int  e;
        prev  = m_st[i];
        pu    = bus.push[i];
        po    = bus.pop[i];
        legal = !((po && q[i].size() == 0) || (pu && !po && q[i].size() == D));
        if (!legal) m_proto = 1'b1;
        if (legal) begin
          if (po) begin
            e = q[i].pop_front();
            if (e[8] && prev == M_ARMED)
              m_st[i] = (bus.data_out == e[7:0]) ? M_DONE : M_FAIL;
          end
          if (pu) begin
            bit tagit;
            tagit = bus.start && (prev == M_IDLE || prev == M_DONE);
            q[i].push_back(int'(bus.flat_data_in[i*W +: W]) | (tagit ? 256 : 0));
            if (tagit) begin
              m_st[i]      = M_ARMED;
              m_arm_cyc[i] = edge_n;
            end
          end
        end
`ifdef SCOREBOARD_LATENCY_CHECK_EN
        if (prev == M_ARMED && m_st[i] == M_ARMED && edge_n - m_arm_cyc[i] >= LAT)
          m_st[i] = M_FAIL;
`endif
      end
    end
    edge_n++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic drive(input bit st, input logic [NR-1:0] ps, input logic [NR-1:0] pp,
                       input logic [NR*W-1:0] fd, input logic [W-1:0] dout);
    bus.start        = st;
    bus.push         = ps;
    bus.pop          = pp;
    bus.flat_data_in = fd;
    bus.data_out     = dout;
  endtask

  task automatic cyc(input bit st, input logic [NR-1:0] ps, input logic [NR-1:0] pp,
                     input logic [NR*W-1:0] fd, input logic [W-1:0] dout);
    drive(st, ps, pp, fd, dout);
    tick();
  endtask

  function automatic logic [W-1:0] front(input int ch);
    int e;
    if (q[ch].size() == 0) return '0;
    e = q[ch][0];
    return e[7:0];
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      logic [NR-1:0] ea, ed, ef;
      for (int i = 0; i < NR; i++) begin
        ea[i] = (m_st[i] == M_ARMED);
        ed[i] = (m_st[i] == M_DONE);
        ef[i] = (m_st[i] == M_FAIL);
      end
      chk("armed", 32'(armed), 32'(ea));
      chk("done", 32'(done), 32'(ed));
      chk("fail", 32'(fail), 32'(ef));
      chk("proto_err", 32'(proto_err), 32'(m_proto));
      chk("prop_signal", 32'(prop_signal), 32'(~|ef & ~m_proto));
      chk("data_out_vld", 32'(bus.data_out_vld), 32'(|bus.pop));
    end
  end

  initial begin
    drive(1'b0, '0, '0, '0, '0);
    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("reset_prop", 32'(prop_signal), 32'd1);
    chk("reset_flags", {armed, done, fail, 3'b000, proto_err}, 32'd0);
    chk("reset_vld", 32'(bus.data_out_vld), 32'd0);

    // Tag the third word on channel 0 and pop it out intact.
    cyc(1'b0, 4'b0001, 4'b0000, 32'h0000_0011, 8'h00);
    cyc(1'b0, 4'b0001, 4'b0000, 32'h0000_0022, 8'h00);
    cyc(1'b1, 4'b0001, 4'b0000, 32'h0000_0033, 8'h00);
    chk("arm_ch0", 32'(armed), 32'h1);
    cyc(1'b0, 4'b0000, 4'b0001, 32'h0, 8'h11);
    cyc(1'b0, 4'b0000, 4'b0001, 32'h0, 8'h22);
    chk("not_done_early", 32'(done), 32'h0);
    cyc(1'b0, 4'b0000, 4'b0001, 32'h0, 8'h33);
    chk("done_ch0", 32'(done), 32'h1);
    chk("no_fail_ch0", 32'(fail), 32'h0);
    cyc(1'b0, 4'b0000, 4'b0000, 32'h0, 8'h00);

    // Same sequence, corrupted tagged word: sticky fail until reset.
    rst = 1'b1;
    cyc(1'b0, 4'b0000, 4'b0000, 32'h0, 8'h00);
    rst = 1'b0;
    cyc(1'b0, 4'b0001, 4'b0000, 32'h0000_0011, 8'h00);
    cyc(1'b0, 4'b0001, 4'b0000, 32'h0000_0022, 8'h00);
    cyc(1'b1, 4'b0001, 4'b0000, 32'h0000_0033, 8'h00);
    cyc(1'b0, 4'b0000, 4'b0001, 32'h0, 8'h11);
    cyc(1'b0, 4'b0000, 4'b0001, 32'h0, 8'h22);
    cyc(1'b0, 4'b0000, 4'b0001, 32'h0, 8'h34);
    chk("fail_ch0", 32'(fail), 32'h1);
    chk("prop_low", 32'(prop_signal), 32'h0);
    repeat (3) cyc(1'b0, 4'b0000, 4'b0000, 32'h0, 8'h00);
    chk("fail_sticky", 32'(fail), 32'h1);
    rst = 1'b1;
    cyc(1'b0, 4'b0000, 4'b0000, 32'h0, 8'h00);
    rst = 1'b0;
    chk("fail_cleared", 32'(fail), 32'h0);
    chk("prop_restored", 32'(prop_signal), 32'h1);

    // Two channels armed together; channel 2 has one word ahead of its tag.
    cyc(1'b0, 4'b0100, 4'b0000, 32'h0055_0000, 8'h00);
    cyc(1'b1, 4'b0101, 4'b0000, 32'h00C0_00A0, 8'h00);
    chk("arm_dual", 32'(armed), 32'h5);
    cyc(1'b0, 4'b0000, 4'b0001, 32'h0, 8'hA0);
    cyc(1'b0, 4'b0000, 4'b0100, 32'h0, 8'h55);
    chk("dual_partial", {armed, done}, {4'b0100, 4'b0001});
    cyc(1'b0, 4'b0000, 4'b0100, 32'h0, 8'hC0);
    chk("done_dual", 32'(done), 32'h5);
    chk("armed_clear", 32'(armed), 32'h0);

    // Fill channel 1 to DEPTH; push+pop at full is legal, push alone overflows.
    for (int k = 0; k < D; k++)
      cyc(1'b0, 4'b0010, 4'b0000, 32'(k + 16) << 8, 8'h00);
    cyc(1'b0, 4'b0010, 4'b0010, 32'h0000_EE00, front(1));
    chk("full_pushpop_ok", 32'(proto_err), 32'h0);
    cyc(1'b0, 4'b0010, 4'b0000, 32'h0000_EF00, 8'h00);
    chk("overflow", 32'(proto_err), 32'h1);
    rst = 1'b1;
    cyc(1'b0, 4'b0000, 4'b0000, 32'h0, 8'h00);
    rst = 1'b0;

    // Double grant, then underflow on empty channel 3, then reset clears.
    cyc(1'b0, 4'b0000, 4'b0011, 32'h0, 8'h00);
    chk("multi_pop", 32'(proto_err), 32'h1);
    cyc(1'b0, 4'b0000, 4'b1000, 32'h0, 8'h00);
    chk("proto_sticky", 32'(proto_err), 32'h1);
    rst = 1'b1;
    cyc(1'b0, 4'b0000, 4'b0000, 32'h0, 8'h00);
    rst = 1'b0;
    chk("proto_cleared", {proto_err, prop_signal}, 32'h1);

    // Arm channel 1 and never pop it.
    cyc(1'b1, 4'b0010, 4'b0000, 32'h0000_5A00, 8'h00);
    chk("arm_ch1", 32'(armed), 32'h2);
    repeat (3) cyc(1'b0, 4'b0000, 4'b0000, 32'h0, 8'h00);
`ifdef SCOREBOARD_LATENCY_CHECK_EN
    chk("lat_not_yet", 32'(fail), 32'h0);
    cyc(1'b0, 4'b0000, 4'b0000, 32'h0, 8'h00);
    chk("lat_timeout", 32'(fail), 32'h2);
    chk("lat_disarm", 32'(armed), 32'h0);
`else
    repeat (3) cyc(1'b0, 4'b0000, 4'b0000, 32'h0, 8'h00);
    chk("starve_armed", 32'(armed), 32'h2);
    chk("starve_no_fail", 32'(fail), 32'h0);
`endif
    cyc(1'b0, 4'b0000, 4'b0000, 32'h0, 8'h00);
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/arb_fifo_scoreboard.md
# arb_fifo_scoreboard

Multi-channel packet-tracking scoreboard for the arbitrated FIFO array. It watches every channel's push, grant and data in parallel, instead of a single hard-selected channel. It tags one word per channel on `start` and checks that the word emerges unchanged on the shared output after exactly the number of pops that were ahead of it. It also flags FIFO protocol violations and drives a single `prop_signal` for formal assertion at the top level.

## Interface
- `NUM_REQS`, 4: number of FIFO channels (≥1).
- `WIDTH`, 8: data word width.
- `DEPTH`, 8: per-channel FIFO depth (≥2).
- `CNTW`, `$clog2(DEPTH+1)`: occupancy/pending counter width.
- `MAX_LAT`, 64: latency bound in cycles; used only with `SCOREBOARD_LATENCY_CHECK_EN`.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  tag request; arms every channel whose `push` is high this cycle.
- `push`  in  NUM_REQS  per-channel FIFO push.
- `pop`  in  NUM_REQS  per-channel grant/pop; at most one bit high.
- `flat_data_in`  in  NUM_REQS*WIDTH  packed push data; channel i is at bits [(i+1)*WIDTH-1 : i*WIDTH].
- `data_out`  in  WIDTH  shared FIFO output; valid in the same cycle as the pop (first-word-fall-through).
- `data_out_vld`  out  1  `|pop`, combinational.
- `armed`  out  NUM_REQS  channel is waiting for its tagged word.
- `done`  out  NUM_REQS  tagged word exited and matched.
- `fail`  out  NUM_REQS  tagged word mismatched, or timed out; sticky.
- `proto_err`  out  1  sticky protocol violation.
- `prop_signal`  out  1  `~|fail & ~proto_err`.

## Operation
- Each channel runs its own FSM with states IDLE, ARMED, DONE and FAIL. It also holds an occupancy counter `cnt[i]`, a pending counter `pend[i]` and a tag register `tag[i]`.
- Occupancy update: `cnt[i] <= cnt[i] + push[i] - pop[i]` every cycle, in all states.
- IDLE or DONE → ARMED when `start & push[i]` and that push is legal:
  - `tag[i] <= data_in[i]`.
  - `pend[i] <= cnt[i] - pop[i]`, which is the number of words ahead of the tagged word.
- ARMED behaviour on `pop[i]`:
  - if `pend[i] != 0`: `pend[i]` decrements.
  - if `pend[i] == 0`: compare `data_out` with `tag[i]`. Equal → DONE; unequal → FAIL.
- FAIL is terminal until `rst`. A `start` in ARMED or FAIL is ignored for that channel.
- `proto_err` is set, and stays set, on any of the following:
  - more than one `pop` bit high;
  - `pop[i]` with `cnt[i] == 0` (underflow);
  - `push[i] & ~pop[i]` with `cnt[i] == DEPTH` (overflow).
- On an underflow or overflow cycle, `cnt[i]` holds its value and the channel does not arm.
- All arithmetic is unsigned at CNTW bits. A `DEPTH` push while popping the same cycle is legal, and `cnt` stays at `DEPTH`.

## Timing
- Reset values:
  - `armed`, `done`, `fail`: 0.
  - `proto_err`: 0; `prop_signal`: 1.
  - internal `cnt`, `pend`, `tag`: 0; all FSMs IDLE.
- `data_out_vld` is combinational and follows `pop` with zero latency.
- All other outputs are registered and update one cycle after the causing edge.
- A tagged word cannot be popped in its own push cycle. The earliest exit is the cycle after arming, when `pend` is 0.
- Reset mid-operation:
  - Every channel returns to IDLE, `cnt` clears to 0, and sticky flags clear.
  - A `start` in the reset cycle is ignored.
- Simultaneous `start` on several channels arms each one independently.

## Configuration
- `SCOREBOARD_LATENCY_CHECK_EN` defined:
  - Each channel has a latency counter that clears on arming and increments while ARMED.
  - If the counter reaches `MAX_LAT` while the channel is still ARMED, the channel goes to FAIL.
  - The match check wins if it happens in the same cycle as the timeout.
- `SCOREBOARD_LATENCY_CHECK_EN` undefined:
  - No latency counter is built, and `MAX_LAT` is ignored.
  - A channel may stay ARMED indefinitely; starvation is not reported.

## Test plan
- Reset, then idle for 5 cycles → `prop_signal=1`, all flags 0, `data_out_vld=0`.
- Channel 0 pushes 0x11 and 0x22, then pushes 0x33 with `start`. Pop channel 0 three times with `data_out` = 0x11, 0x22, 0x33 → `done[0]=1` one cycle after the third pop, `fail=0`.
- Same sequence, but the third `data_out` is 0x34 → `fail[0]=1` and `prop_signal=0`, and both remain set until `rst`.
- `start` with `push=4'b0101` (ch0 tag 0xA0, ch2 tag 0xC0), then interleaved single pops with the correct data → `done=4'b0101`, `armed=0`.
- Issue `pop=4'b0011`, then separately pop an empty channel 3 → `proto_err=1` one cycle after the first violation. Then assert `rst` → `proto_err=0`, `prop_signal=1`.
- With `SCOREBOARD_LATENCY_CHECK_EN` and `MAX_LAT=4`: arm channel 1 and never pop it → `fail[1]=1` in cycle 4 after arming. Without the macro → `armed[1]` stays 1.
